// File: rtl/data_ram.sv
// Word-organised data memory behind the MEM stage: byte/half/word stores and
// sign/zero-extended loads after WAIT_STATES extra cycles, closed by a one-cycle ready pulse.
module data_ram #(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err
);

  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned AIDX_W = DEPTH_LOG2 + 2;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               cap, acc;

  logic               req_we;
  logic [AIDX_W-1:0]  req_addr;
  logic [31:0]        req_wdata;
  logic [2:0]         req_f3;

  logic               a_we;
  logic [AIDX_W-1:0]  a_addr;
  logic [31:0]        a_wdata;
  logic [2:0]         a_f3;

  logic [31:0]        mem [DEPTH];
  logic [DEPTH_LOG2-1:0] idx;
  logic [31:0]        word, shifted, ld, wlanes, rdata_nxt;
  logic [3:0]         be;
  logic               bad, wr_en;

  // Address bits above the array size alias and are intentionally dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:AIDX_W];

  // Next-state and access-edge decode
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cap       = 1'b0;
    acc       = 1'b0;
    case (state)
      IDLE: begin
        if (ce) begin
          cap     = 1'b1;
          cnt_nxt = CNT_W'(WAIT_STATES);
          if (WAIT_STATES == 0) begin
            state_nxt = DONE;
            acc       = 1'b1;
          end else begin
            state_nxt = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_nxt = DONE;
          acc       = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With zero wait states the access uses the live request, otherwise the captured one.
  assign a_we    = (state == IDLE) ? we              : req_we;
  assign a_addr  = (state == IDLE) ? addr[AIDX_W-1:0] : req_addr;
  assign a_wdata = (state == IDLE) ? wdata           : req_wdata;
  assign a_f3    = (state == IDLE) ? funct3          : req_f3;

  assign idx     = a_addr[AIDX_W-1:2];
  assign word    = mem[idx];
  assign shifted = word >> {a_addr[1:0], 3'b000};

  // Size/sign decode: lane enables, store lanes, load extension, error detect
  always_comb begin
    bad    = 1'b0;
    be     = 4'b0000;
    wlanes = 32'h0;
    ld     = 32'h0;
    case (a_f3)
      3'b000: begin
        be     = 4'b0001 << a_addr[1:0];
        wlanes = {4{a_wdata[7:0]}};
        ld     = {{24{shifted[7]}}, shifted[7:0]};
      end
      3'b001: begin
        bad    = a_addr[0];
        be     = a_addr[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{a_wdata[15:0]}};
        ld     = {{16{shifted[15]}}, shifted[15:0]};
      end
      3'b010: begin
        bad    = |a_addr[1:0];
        be     = 4'b1111;
        wlanes = a_wdata;
        ld     = word;
      end
      3'b100: begin
        bad = a_we;
        ld  = {24'h0, shifted[7:0]};
      end
      3'b101: begin
        bad = a_we | a_addr[0];
        ld  = {16'h0, shifted[15:0]};
      end
      default: bad = 1'b1;
    endcase
  end

  assign wr_en     = acc & a_we & ~bad & ~rst;
  assign rdata_nxt = (acc && !a_we && !bad) ? ld : 32'h0;

  // Control state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      ready <= 1'b0;
      err   <= 1'b0;
      rdata <= 32'h0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ready <= acc;
      err   <= acc & bad;
      rdata <= rdata_nxt;
    end
  end

  // Request capture
  always_ff @(posedge clk) begin
    if (cap) begin
      req_we    <= we;
      req_addr  <= addr[AIDX_W-1:0];
      req_wdata <= wdata;
      req_f3    <= funct3;
    end
  end

  // Byte-lane array write; the array has no reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_en && be[i]) mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_data_ram.sv
// Directed bench for data_ram: three instances with WAIT_STATES of 1, 3 and 0.
module tb_data_ram;

  logic        clk = 1'b0;
  logic        rst1, rst3, rst0;
  logic        ce1, ce3, ce0;
  logic        we;
  logic [31:0] addr, wdata;
  logic [2:0]  funct3;
  logic [31:0] rd1, rd3, rd0;
  logic        rdy1, rdy3, rdy0;
  logic        er1, er3, er0;

  int          sel;
  logic [31:0] cur_rd;
  logic        cur_rdy, cur_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_ram #(.DEPTH_LOG2(10), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .rst(rst1), .ce(ce1), .we(we), .addr(addr), .wdata(wdata),
    .funct3(funct3), .rdata(rd1), .ready(rdy1), .err(er1));
  data_ram #(.DEPTH_LOG2(10), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst3), .ce(ce3), .we(we), .addr(addr), .wdata(wdata),
    .funct3(funct3), .rdata(rd3), .ready(rdy3), .err(er3));
  data_ram #(.DEPTH_LOG2(10), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst0), .ce(ce0), .we(we), .addr(addr), .wdata(wdata),
    .funct3(funct3), .rdata(rd0), .ready(rdy0), .err(er0));

  always_comb begin
    cur_rd  = rd1;
    cur_rdy = rdy1;
    cur_err = er1;
    if (sel == 3) begin
      cur_rd = rd3; cur_rdy = rdy3; cur_err = er3;
    end else if (sel == 0) begin
      cur_rd = rd0; cur_rdy = rdy0; cur_err = er0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_ce(input logic v);
    ce1 = (sel == 1) ? v : 1'b0;
    ce3 = (sel == 3) ? v : 1'b0;
    ce0 = (sel == 0) ? v : 1'b0;
  endtask

  // One isolated access on the selected instance; checks latency, err and (if asked) rdata.
  task automatic access(input string tag, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] f3,
                        input logic [31:0] exp_rd, input logic exp_err, input logic chk_rd);
    int got;
    logic [31:0] rd_s;
    logic        er_s;
    got  = -1;
    rd_s = 32'h0;
    er_s = 1'b0;
    @(negedge clk);
    we = w; addr = a; wdata = d; funct3 = f3;
    set_ce(1'b1);
    @(posedge clk);
    @(negedge clk);
    set_ce(1'b0);
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) @(negedge clk);
      if (cur_rdy) begin
        got  = k;
        rd_s = cur_rd;
        er_s = cur_err;
        break;
      end
    end
    check({tag, "_lat"}, 32'(got), 32'(sel + 1));
    check({tag, "_err"}, 32'(er_s), 32'(exp_err));
    if (chk_rd) check({tag, "_rdata"}, rd_s, exp_rd);
  endtask

  logic [31:0] vals [4];
  int          seen;

  initial begin
    rst1 = 1'b1; rst3 = 1'b1; rst0 = 1'b1;
    ce1 = 1'b0; ce3 = 1'b0; ce0 = 1'b0;
    we = 1'b0; addr = 32'h0; wdata = 32'h0; funct3 = 3'b010;
    sel = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(rdy1), 32'h0);
    check("rst_err",   32'(er1),  32'h0);
    check("rst_rdata", rd1,       32'h0);
    rst1 = 1'b0; rst3 = 1'b0; rst0 = 1'b0;

    // Word store / load
    access("sw_10",  1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0,        1'b0, 1'b0);
    access("lw_10",  1'b0, 32'h10, 32'h0,        3'b010, 32'hDEADBEEF, 1'b0, 1'b1);

    // Byte store into top lane, signed and unsigned reloads
    access("sb_13",  1'b1, 32'h13, 32'h00000080, 3'b000, 32'h0,        1'b0, 1'b0);
    access("lb_13",  1'b0, 32'h13, 32'h0,        3'b000, 32'hFFFFFF80, 1'b0, 1'b1);
    access("lbu_13", 1'b0, 32'h13, 32'h0,        3'b100, 32'h00000080, 1'b0, 1'b1);
    access("lw_10b", 1'b0, 32'h10, 32'h0,        3'b010, 32'h80ADBEEF, 1'b0, 1'b1);

    // Misalignment and illegal funct3 leave memory untouched
    access("sw_14",  1'b1, 32'h14, 32'h11223344, 3'b010, 32'h0,        1'b0, 1'b0);
    access("lh_11",  1'b0, 32'h11, 32'h0,        3'b001, 32'h0,        1'b1, 1'b1);
    access("sw_16",  1'b1, 32'h16, 32'hFFFFFFFF, 3'b010, 32'h0,        1'b1, 1'b1);
    access("sbu_14", 1'b1, 32'h14, 32'h000000FF, 3'b100, 32'h0,        1'b1, 1'b1);
    access("ld_f3",  1'b0, 32'h14, 32'h0,        3'b011, 32'h0,        1'b1, 1'b1);
    access("lw_14",  1'b0, 32'h14, 32'h0,        3'b010, 32'h11223344, 1'b0, 1'b1);

    // Half store into upper lanes
    access("sh_16",  1'b1, 32'h16, 32'h0000CAFE, 3'b001, 32'h0,        1'b0, 1'b0);
    access("lh_16",  1'b0, 32'h16, 32'h0,        3'b001, 32'hFFFFCAFE, 1'b0, 1'b1);
    access("lhu_16", 1'b0, 32'h16, 32'h0,        3'b101, 32'h0000CAFE, 1'b0, 1'b1);
    access("lw_14b", 1'b0, 32'h14, 32'h0,        3'b010, 32'hCAFE3344, 1'b0, 1'b1);

    // Address aliasing above the array size
    access("sw_1000", 1'b1, 32'h1000, 32'hA5A5A5A5, 3'b010, 32'h0,        1'b0, 1'b0);
    access("lw_0000", 1'b0, 32'h0000, 32'h0,        3'b010, 32'hA5A5A5A5, 1'b0, 1'b1);

    // Reset in the first BUSY cycle cancels the store
    sel = 3;
    access("sw_20",  1'b1, 32'h20, 32'hCAFEF00D, 3'b010, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    we = 1'b1; addr = 32'h20; wdata = 32'h12345678; funct3 = 3'b010;
    set_ce(1'b1);
    @(posedge clk);
    @(negedge clk);
    set_ce(1'b0);
    rst3 = 1'b1;
    @(negedge clk);
    rst3 = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rdy3 || er3 || rd3 != 32'h0) seen++;
    end
    check("rst_cancel_outputs", 32'(seen), 32'h0);
    access("lw_20",  1'b0, 32'h20, 32'h0, 3'b010, 32'hCAFEF00D, 1'b0, 1'b1);

    // Zero wait states: back-to-back loads with ce held high
    sel = 0;
    vals[0] = 32'h01020304; vals[1] = 32'hF0E0D0C0;
    vals[2] = 32'h55AA55AA; vals[3] = 32'h0BADF00D;
    for (int i = 0; i < 4; i++)
      access("sw_ws0", 1'b1, 32'h40 + 32'(4*i), vals[i], 3'b010, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    we = 1'b0; addr = 32'h40; funct3 = 3'b010;
    set_ce(1'b1);
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k % 2 == 1) begin
        check("q_ready", 32'(rdy0), 32'h1);
        check("q_rdata", rd0, vals[(k-1)/2]);
        if ((k+1)/2 < 4) addr = 32'h40 + 32'(4*((k+1)/2));
        else set_ce(1'b0);
      end else begin
        check("q_gap", 32'(rdy0), 32'h0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
